// File: rtl/chip8_kbd_pkg.sv
// Shared definitions for the Chip-8 PS/2 keypad front end.
// Contains frame FSM states, set-2 prefix bytes, and the scancode-to-hex-key map.
package chip8_kbd_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   // Set-2 make codes laid out as the 4x4 block 1234/QWER/ASDF/ZXCV
   localparam logic [7:0] SC_K0 = 8'h22;
   localparam logic [7:0] SC_K1 = 8'h16;
   localparam logic [7:0] SC_K2 = 8'h1E;
   localparam logic [7:0] SC_K3 = 8'h26;
   localparam logic [7:0] SC_K4 = 8'h15;
   localparam logic [7:0] SC_K5 = 8'h1D;
   localparam logic [7:0] SC_K6 = 8'h24;
   localparam logic [7:0] SC_K7 = 8'h1C;
   localparam logic [7:0] SC_K8 = 8'h1B;
   localparam logic [7:0] SC_K9 = 8'h23;
   localparam logic [7:0] SC_KA = 8'h1A;
   localparam logic [7:0] SC_KB = 8'h21;
   localparam logic [7:0] SC_KC = 8'h25;
   localparam logic [7:0] SC_KD = 8'h2D;
   localparam logic [7:0] SC_KE = 8'h2B;
   localparam logic [7:0] SC_KF = 8'h2A;

   typedef struct packed {
      logic       hit;
      logic [3:0] idx;
   } kp_hit_t;

   function automatic kp_hit_t kp_map(input logic [7:0] sc);
      kp_hit_t r;
      r.hit = 1'b1;
      r.idx = 4'h0;
      case (sc)
         SC_K0:   r.idx = 4'h0;
         SC_K1:   r.idx = 4'h1;
         SC_K2:   r.idx = 4'h2;
         SC_K3:   r.idx = 4'h3;
         SC_K4:   r.idx = 4'h4;
         SC_K5:   r.idx = 4'h5;
         SC_K6:   r.idx = 4'h6;
         SC_K7:   r.idx = 4'h7;
         SC_K8:   r.idx = 4'h8;
         SC_K9:   r.idx = 4'h9;
         SC_KA:   r.idx = 4'hA;
         SC_KB:   r.idx = 4'hB;
         SC_KC:   r.idx = 4'hC;
         SC_KD:   r.idx = 4'hD;
         SC_KE:   r.idx = 4'hE;
         SC_KF:   r.idx = 4'hF;
         default: r.hit = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, clock glitch filter,
// 11-bit frame FSM and mid-frame timeout. Outputs are combinational one-cycle pulses.
module ps2_frame_rx
   import chip8_kbd_pkg::*;
#(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 25000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       err_o
);

   localparam int FCW = $clog2(FILTER + 1);
   localparam int TW  = $clog2(TIMEOUT + 1);

   logic [1:0]     clk_sync_q, dat_sync_q;
   logic           filt_q, filt_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic [1:0]     st_q, st_d;
   logic [7:0]     sh_q, sh_d;
   logic [2:0]     bc_q, bc_d;
   logic           perr_q, perr_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic           fall, dat, byte_valid, err;

   assign dat = dat_sync_q[1];

   always_comb begin
      filt_d = filt_q;
      fcnt_d = fcnt_q;
      if (clk_sync_q[1] == filt_q) begin
         fcnt_d = '0;
      end else if (fcnt_q == FCW'(FILTER - 1)) begin
         filt_d = clk_sync_q[1];
         fcnt_d = '0;
      end else begin
         fcnt_d = fcnt_q + 1'b1;
      end
   end

   assign fall = filt_q & ~filt_d;

   always_comb begin
      st_d       = st_q;
      sh_d       = sh_q;
      bc_d       = bc_q;
      perr_d     = perr_q;
      tmo_d      = tmo_q;
      byte_valid = 1'b0;
      err        = 1'b0;
      if (st_q != ST_IDLE) tmo_d = fall ? '0 : tmo_q + 1'b1;
      case (st_q)
         ST_IDLE: if (fall) begin
            if (!dat) begin
               st_d   = ST_DATA;
               bc_d   = '0;
               perr_d = 1'b0;
               tmo_d  = '0;
            end else begin
               err = 1'b1;
            end
         end
         ST_DATA: if (fall) begin
            sh_d = {dat, sh_q[7:1]};
            bc_d = bc_q + 1'b1;
            if (bc_q == 3'd7) st_d = ST_PARITY;
         end
         ST_PARITY: if (fall) begin
            perr_d = ~(^{dat, sh_q});
            st_d   = ST_STOP;
         end
         default: if (fall) begin
            st_d = ST_IDLE;
            if (!dat || perr_q) err = 1'b1;
            else                byte_valid = 1'b1;
         end
      endcase
      // An edge in the same cycle restarts the count, so timeout cannot coincide with it
      if (st_q != ST_IDLE && !fall && tmo_q == TW'(TIMEOUT - 1)) begin
         err  = 1'b1;
         st_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         filt_q     <= 1'b1;
         fcnt_q     <= '0;
         st_q       <= ST_IDLE;
         sh_q       <= '0;
         bc_q       <= '0;
         perr_q     <= 1'b0;
         tmo_q      <= '0;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
         dat_sync_q <= {dat_sync_q[0], ps2_data_i};
         filt_q     <= filt_d;
         fcnt_q     <= fcnt_d;
         st_q       <= st_d;
         sh_q       <= sh_d;
         bc_q       <= bc_d;
         perr_q     <= perr_d;
         tmo_q      <= tmo_d;
      end
   end

   assign byte_o       = sh_q;
   assign byte_valid_o = byte_valid;
   assign err_o        = err;

endmodule

// File: rtl/ps2_keypad.sv
// Chip-8 hex keypad from a PS/2 set-2 keyboard: prefix tracking, key map,
// held-key register and one-cycle change events for FX0A.
module ps2_keypad
   import chip8_kbd_pkg::*;
#(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 25000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] keys,
   output logic        evt_valid,
   output logic [3:0]  evt_key,
   output logic        evt_pressed,
   output logic        frame_err
);

   logic [1:0]  rst_sync_q;
   logic        rst_i_n;
   logic [7:0]  rx_byte;
   logic        rx_valid, rx_err;
   kp_hit_t     map;
   logic [15:0] keys_q, keys_d;
   logic        evt_valid_q, evt_valid_d;
   logic [3:0]  evt_key_q, evt_key_d;
   logic        evt_pressed_q, evt_pressed_d;
   logic        frame_err_q;
   logic        brk_q, brk_d, ext_q, ext_d;

   // Reset asserts immediately but releases on a clock edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_i_n = rst_sync_q[1];

   ps2_frame_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) u_rx (
      .clk          (clk),
      .rst_n        (rst_i_n),
      .ps2_clk_i    (ps2_clk),
      .ps2_data_i   (ps2_data),
      .byte_o       (rx_byte),
      .byte_valid_o (rx_valid),
      .err_o        (rx_err)
   );

   assign map = kp_map(rx_byte);

   always_comb begin
      keys_d        = keys_q;
      evt_valid_d   = 1'b0;
      evt_key_d     = evt_key_q;
      evt_pressed_d = evt_pressed_q;
      brk_d         = brk_q;
      ext_d         = ext_q;
      if (rx_err) begin
         brk_d = 1'b0;
         ext_d = 1'b0;
      end else if (rx_valid) begin
         if (rx_byte == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (rx_byte == PS2_BRK) begin
            brk_d = 1'b1;
         end else begin
            // Only a real state change emits an event; typematic repeats fall out here
            if (!ext_q && map.hit && keys_q[map.idx] != ~brk_q) begin
               keys_d[map.idx] = ~brk_q;
               evt_valid_d     = 1'b1;
               evt_key_d       = map.idx;
               evt_pressed_d   = ~brk_q;
            end
            brk_d = 1'b0;
            ext_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
         keys_q        <= '0;
         evt_valid_q   <= 1'b0;
         evt_key_q     <= '0;
         evt_pressed_q <= 1'b0;
         frame_err_q   <= 1'b0;
         brk_q         <= 1'b0;
         ext_q         <= 1'b0;
      end else begin
         keys_q        <= keys_d;
         evt_valid_q   <= evt_valid_d;
         evt_key_q     <= evt_key_d;
         evt_pressed_q <= evt_pressed_d;
         frame_err_q   <= rx_err;
         brk_q         <= brk_d;
         ext_q         <= ext_d;
      end
   end

   assign keys        = keys_q;
   assign evt_valid   = evt_valid_q;
   assign evt_key     = evt_key_q;
   assign evt_pressed = evt_pressed_q;
   assign frame_err   = frame_err_q;

endmodule
